// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID capture register, stall/redirect and fault halt.
// Latency: word at iaddr_o in cycle N is presented on instr_o/valid_o in cycle N+1.
// Backpressure: stall_i freezes all state; redirect_i overrides stall and inserts one bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] iaddr_o,
  input  logic [31:0] idata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [31:0] DEPTH_W         = 32'(IMEM_DEPTH);
  localparam logic [1:0]  CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0]  CAUSE_OOR       = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;          // fetch PC driven to memory
  logic [31:0] instr_q, instr_d;    // IF/ID instruction
  logic [31:0] if_pc_q, if_pc_d;    // PC of the captured instruction
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] cnt_q, cnt_d;
  logic        out_of_range;

  // Word index compared in 32 bits so any IMEM_DEPTH value is handled.
  assign out_of_range = ({2'b00, pc_q[31:2]} >= DEPTH_W);

  // Next-state: redirect beats stall, stall beats range check, range check beats advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    if (state_q == RUN) begin
      if (redirect_i) begin
        valid_d = 1'b0;
        pc_d    = redirect_target_i;
        if (redirect_target_i[1:0] != 2'b00) begin
          fault_d = 1'b1;
          cause_d = CAUSE_MISALIGN;
          state_d = HALTED;
        end
      end else if (stall_i) begin
        // everything holds
      end else if (out_of_range) begin
        valid_d = 1'b0;
        fault_d = 1'b1;
        cause_d = CAUSE_OOR;
        state_d = HALTED;
      end else begin
        instr_d = idata_i;
        if_pc_d = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
        cnt_d   = cnt_q + 32'd1;
      end
    end else begin
      // Halted: only reset leaves this state; fault flags stay sticky.
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      if_pc_q <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign iaddr_o       = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = if_pc_q;
  assign pc_plus4_o    = if_pc_q + 32'd4;
  assign valid_o       = valid_q;
  assign fault_o       = fault_q;
  assign fault_cause_o = cause_q;
  assign fetch_cnt_o   = cnt_q;

endmodule
